muskbus_mem_responder: RTL and testbench
========================================

// Module: muskbus_mem_responder
// PURPOSE
//  Responder (memory) end of Muskbus: accepts line read/write requests issued by the core-side
//  MuskbusMux and answers them from an internal line-organised RAM after a fixed latency.
//  Serves as the bench/sim memory behind MuskCore's i/d caches; one request in flight at a time.
// PARAMETERS
//  MEM_LINES  1024  number of 64-byte lines stored (power of 2)
//  LATENCY    4     cycles from request-header accept to first response beat (>=1)
// PORTS
//  clk        in   1    clock, all logic on posedge
//  reset      in   1    synchronous, active-low reset (0 = reset)
//  reqcyc     in   1    request beat valid
//  req        in   64   header beat: byte address; write data beats: data word
//  reqtag     in   13   [12]=1 write / 0 read; [11:0]=transaction id
//  reqack     out  1    request beat accepted this cycle
//  respcyc    out  1    response beat valid
//  resp       out  64   response data word
//  resptag    out  13   echo of the accepted reqtag
//  respack    in   1    response beat consumed this cycle
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, beat_cnt=0, lat_cnt=0; reqack=0, respcyc=0,
//    resp=0, resptag=0. RAM contents not cleared. Reset mid-transaction aborts it; no beats after.
//  - Addressing: line = req[6 +: $clog2(MEM_LINES)] (upper bits ignored, wrap modulo MEM_LINES);
//    req[5:0] ignored, transfers always line-aligned, beats in order 0..7 (beat k = bytes 8k..8k+7).
//  - All outputs registered. reqack is a one-cycle pulse per accepted beat.
//  - States: IDLE, WDATA, WAIT, RESP.
//  - IDLE: reqcyc=1 -> latch line, tag; reqack=1 next cycle (header accepted).
//      read -> WAIT, lat_cnt=LATENCY-1; write -> WDATA, beat_cnt=0.
//  - WDATA: each cycle reqcyc=1 & reqack deasserted-previous-cycle not required: accept one beat
//    per cycle reqcyc=1, write RAM[line][beat_cnt]=req, pulse reqack, beat_cnt++;
//    after beat 7 -> WAIT, lat_cnt=LATENCY-1. reqcyc=0 stalls (no accept, no count).
//  - WAIT: lat_cnt decrements each cycle; at 0 -> RESP with beat_cnt=0.
//  - RESP read: respcyc=1, resp=RAM[line][beat_cnt], resptag=tag; hold all three stable until
//    respack=1; on respack advance beat_cnt; after beat 7 acked -> IDLE, respcyc=0 same edge.
//  - RESP write: single beat, respcyc=1, resp=0, resptag=tag; on respack -> IDLE.
//  - Requests arriving outside IDLE/WDATA are not acked; initiator must hold reqcyc.
//  - respack while respcyc=0 ignored. Back-to-back: IDLE can accept new header the cycle after
//    the final respack (no overlap of request and response phases).
//  - Write-then-read same line returns new data (write completes before write response).
//  - beat_cnt 3 bits, lat_cnt $clog2(LATENCY+1) bits; no other arithmetic.
// STRUCTURE
//  - Package MUSKBUS_PKG: TAG_WRITE_BIT=12, TAG_W=13, BEATS_PER_LINE=8, state_t enum
//    {IDLE,WDATA,WAIT,RESP}; shared with future bus monitors.
//  - Sub-module musk_line_ram: MEM_LINES*8 x 64 single-port, 1 write or 1 read per cycle,
//    registered read (1-cycle) - FSM prefetches next beat so respcyc hold rule is met.
//  - Top: FSM + counters + output registers.
// TESTING
//  - Reset held 3 cycles with reqcyc=1 -> reqack=0, respcyc=0, resp=0 throughout; release, IDLE.
//  - Write line 0x40 data 0x1111..0x8888 (8 beats, respack=1) -> 9 reqack pulses, one resp beat
//    resptag=0x1005 after LATENCY; then read 0x40 tag 0x007 -> first respcyc exactly LATENCY+1
//    cycles after header, beats 0x1111..0x8888 in order, resptag=0x007.
//  - Read with respack low for 5 cycles on beat 2 -> resp/resptag stable all 5 cycles, no beat lost.
//  - Address wrap: write addr MEM_LINES*64+0x40, read 0x40 -> same data returned.
//  - Write with reqcyc gaps between data beats -> only reqcyc=1 beats counted, data intact.
//  - Reset asserted during RESP beat 4 -> respcyc=0 next cycle; next read serves normally.

Source files
------------

// File: rtl/muskbus_mem_responder_pkg.sv
// Shared Muskbus definitions: tag layout, line geometry and responder FSM states.
package muskbus_mem_responder_pkg;

    localparam int TAG_WRITE_BIT  = 12;
    localparam int TAG_W          = 13;
    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);
    localparam int DATA_W         = 64;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WAIT,
        RESP
    } state_t;

    function automatic logic is_write(input logic [TAG_W-1:0] tag);
        return tag[TAG_WRITE_BIT];
    endfunction

endpackage

// File: rtl/muskbus_mem_responder_if.sv
// Muskbus request/response channel between the core-side initiator and a memory responder.
interface muskbus_mem_responder_if;
    import muskbus_mem_responder_pkg::*;

    logic              reqcyc;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              reqack;
    logic              respcyc;
    logic [DATA_W-1:0] resp;
    logic [TAG_W-1:0]  resptag;
    logic              respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );

endinterface

// File: rtl/muskbus_mem_responder_line_ram.sv
// Single-port word RAM holding whole lines; a write suppresses that cycle's read, reads land one cycle later.
module muskbus_mem_responder_line_ram
    import muskbus_mem_responder_pkg::*;
#(
    parameter int DEPTH = 8192
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rd_data_q <= mem[addr];
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/muskbus_mem_responder.sv
// Muskbus memory responder: accepts one line read/write at a time and answers after a fixed latency.
module muskbus_mem_responder
    import muskbus_mem_responder_pkg::*;
#(
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    muskbus_mem_responder_if.slave bus
);

    localparam int LINE_W = $clog2(MEM_LINES);
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam int RAM_AW = LINE_W + BEAT_W;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              reqack_q, reqack_d;
    logic              respcyc_q, respcyc_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [TAG_W-1:0]  resptag_q, resptag_d;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    muskbus_mem_responder_line_ram #(
        .DEPTH(MEM_LINES * BEATS_PER_LINE)
    ) u_line_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(bus.req),
        .rdata(ram_rdata)
    );

    // The RAM always reads one beat ahead of the beat on resp, so a respack can
    // load the next word straight from the RAM output without a bubble.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        tag_d      = tag_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        reqack_d   = 1'b0;
        respcyc_d  = respcyc_q;
        resp_d     = resp_q;
        resptag_d  = resptag_q;
        ram_we     = 1'b0;
        ram_addr   = {line_q, {BEAT_W{1'b0}}};

        case (state_q)
            IDLE: begin
                ram_addr = {bus.req[6 +: LINE_W], {BEAT_W{1'b0}}};
                if (bus.reqcyc) begin
                    line_d     = bus.req[6 +: LINE_W];
                    tag_d      = bus.reqtag;
                    reqack_d   = 1'b1;
                    beat_cnt_d = '0;
                    if (is_write(bus.reqtag)) begin
                        state_d = WDATA;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end

            WDATA: begin
                ram_addr = {line_q, beat_cnt_q};
                if (bus.reqcyc) begin
                    ram_we     = 1'b1;
                    reqack_d   = 1'b1;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end

            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d    = RESP;
                    beat_cnt_d = '0;
                    respcyc_d  = 1'b1;
                    resptag_d  = tag_q;
                    resp_d     = is_write(tag_q) ? '0 : ram_rdata;
                    ram_addr   = {line_q, BEAT_W'(1)};
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end

            RESP: begin
                ram_addr = {line_q, beat_cnt_q + BEAT_W'(1)};
                if (bus.respack) begin
                    if (is_write(tag_q) || beat_cnt_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        resp_d     = ram_rdata;
                        ram_addr   = {line_q, beat_cnt_q + BEAT_W'(2)};
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            line_q     <= '0;
            tag_q      <= '0;
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
            reqack_q   <= 1'b0;
            respcyc_q  <= 1'b0;
            resp_q     <= '0;
            resptag_q  <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            tag_q      <= tag_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            reqack_q   <= reqack_d;
            respcyc_q  <= respcyc_d;
            resp_q     <= resp_d;
            resptag_q  <= resptag_d;
        end
    end

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;

endmodule

// File: tb/tb_muskbus_mem_responder.sv
// Randomized bench for muskbus_mem_responder against a line-array model of the memory.
module tb_muskbus_mem_responder;
    import muskbus_mem_responder_pkg::*;

    localparam int MEM_LINES = 1024;
    localparam int LATENCY   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muskbus_mem_responder_if bus();

    muskbus_mem_responder #(
        .MEM_LINES(MEM_LINES),
        .LATENCY  (LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] model [MEM_LINES*8];
    logic [63:0] wbuf  [8];
    int          written[$];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr / 64) % MEM_LINES);
    endfunction

    function automatic logic [63:0] addr_for_line(input int ln);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r - ((r / 64) % MEM_LINES) * 64 + 64'(ln) * 64;
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [11:0] id, input int gap_pct);
        int acks = 0;
        int cyc;
        int ln = line_of(addr);
        bus.respack = 1'b0;
        bus.reqcyc  = 1'b1;
        bus.req     = addr;
        bus.reqtag  = {1'b1, id};
        tick();
        if (bus.reqack) acks++;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
                bus.reqcyc = 1'b0;
                bus.req    = {$urandom, $urandom};
                tick();
                if (bus.reqack) acks++;
            end
            bus.reqcyc = 1'b1;
            bus.req    = wbuf[k];
            tick();
            if (bus.reqack) acks++;
            model[ln*8 + k] = wbuf[k];
        end
        bus.reqcyc = 1'b0;
        cyc = 1;
        while (!bus.respcyc && cyc < 64) begin
            tick();
            cyc++;
            if (bus.reqack) acks++;
        end
        chk_val("wr_latency", 64'(cyc), 64'(LATENCY + 1));
        chk_val("wr_acks", 64'(acks), 64'd9);
        chk_val("wr_resptag", 64'(bus.resptag), 64'({1'b1, id}));
        chk_val("wr_resp", bus.resp, 64'd0);
        bus.respack = 1'b1;
        tick();
        bus.respack = 1'b0;
        chk_val("wr_done", 64'(bus.respcyc), 64'd0);
        written.push_back(ln);
        $display("write line=%0d id=%h acks=%0d latency=%0d", ln, id, acks, cyc);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [11:0] id,
                           input int stall_beat, input int stall_len, input bit rand_stall);
        int cyc;
        int n;
        int ln = line_of(addr);
        bus.respack = 1'b0;
        bus.reqcyc  = 1'b1;
        bus.req     = addr;
        bus.reqtag  = {1'b0, id};
        tick();
        bus.reqcyc = 1'b0;
        chk_val("rd_hdr_ack", 64'(bus.reqack), 64'd1);
        cyc = 1;
        while (!bus.respcyc && cyc < 64) begin
            tick();
            cyc++;
        end
        chk_val("rd_latency", 64'(cyc), 64'(LATENCY + 1));
        for (int k = 0; k < 8; k++) begin
            chk_val("rd_cyc", 64'(bus.respcyc), 64'd1);
            chk_val("rd_data", bus.resp, model[ln*8 + k]);
            chk_val("rd_tag", 64'(bus.resptag), 64'({1'b0, id}));
            n = (k == stall_beat) ? stall_len : (rand_stall ? int'($urandom_range(2)) : 0);
            for (int s = 0; s < n; s++) begin
                tick();
                chk_val("rd_hold_cyc", 64'(bus.respcyc), 64'd1);
                chk_val("rd_hold_data", bus.resp, model[ln*8 + k]);
                chk_val("rd_hold_tag", 64'(bus.resptag), 64'({1'b0, id}));
            end
            bus.respack = 1'b1;
            tick();
            bus.respack = 1'b0;
        end
        chk_val("rd_done", 64'(bus.respcyc), 64'd0);
        $display("read  line=%0d id=%h latency=%0d stall_beat=%0d", ln, id, cyc, stall_beat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ln;
        int cyc;
        bus.reqcyc  = 1'b1;
        bus.req     = {$urandom, $urandom};
        bus.reqtag  = 13'h0003;
        bus.respack = 1'b0;
        reset       = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("rst_reqack", 64'(bus.reqack), 64'd0);
            chk_val("rst_respcyc", 64'(bus.respcyc), 64'd0);
            chk_val("rst_resp", bus.resp, 64'd0);
        end
        chk_val("rst_resptag", 64'(bus.resptag), 64'd0);
        bus.reqcyc = 1'b0;
        reset      = 1'b1;
        tick();
        chk_val("idle_respcyc", 64'(bus.respcyc), 64'd0);
        $display("reset sequence complete");

        for (int k = 0; k < 8; k++) wbuf[k] = 64'h1111 * 64'(k + 1);
        do_write(64'h40, 12'h005, 0);
        do_read(64'h40, 12'h007, 8, 0, 1'b0);

        do_read(64'h40, 12'h00A, 2, 5, 1'b0);

        // respack with no response pending must not disturb anything
        bus.respack = 1'b1;
        repeat (3) tick();
        bus.respack = 1'b0;
        chk_val("idle_respack", 64'(bus.respcyc), 64'd0);

        for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'(MEM_LINES) * 64 + 64'h40 + 64'h13, 12'h011, 0);
        do_read(64'h40, 12'h012, 8, 0, 1'b0);

        for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'h1234_5680, 12'h020, 60);
        do_read(64'h1234_5680, 12'h021, 8, 0, 1'b1);

        // abort a read while beat 4 is on the bus
        ln = line_of(64'h1234_5680);
        bus.reqcyc = 1'b1;
        bus.req    = 64'h1234_5680;
        bus.reqtag = 13'h0030;
        tick();
        bus.reqcyc = 1'b0;
        cyc = 1;
        while (!bus.respcyc && cyc < 64) begin
            tick();
            cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            bus.respack = 1'b1;
            tick();
        end
        bus.respack = 1'b0;
        chk_val("abort_beat4", bus.resp, model[ln*8 + 4]);
        reset = 1'b0;
        tick();
        chk_val("abort_respcyc", 64'(bus.respcyc), 64'd0);
        chk_val("abort_resp", bus.resp, 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        chk_val("abort_quiet", 64'(bus.respcyc), 64'd0);
        $display("reset during response beat 4 handled");
        do_read(64'h1234_5680, 12'h031, 8, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1) == 0 || written.size() < 3) begin
                for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
                do_write(addr_for_line(int'($urandom_range(MEM_LINES - 1))),
                         12'($urandom), int'($urandom_range(50)));
            end else begin
                ln = written[$urandom_range(written.size() - 1)];
                do_read(addr_for_line(ln), 12'($urandom),
                        int'($urandom_range(8)), int'($urandom_range(4)), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
